// File: rtl/cpu_pkg.sv
// Shared types and constants for the HI/LO capture slice of the CPU datapath.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  typedef enum logic {
    RD_IDLE    = 1'b0,
    RD_HI_PEND = 1'b1
  } rd_state_t;

endpackage

// File: rtl/hilo_read_seq.sv
// Read sequencer: serves single LO/HI reads or a back-to-back LO-then-HI pair.
// bus_oe is a valid strobe with no ready: the consumer must take bus_out in the cycle bus_oe=1.
module hilo_read_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             rd_lo,
  input  logic             rd_hi,
  input  logic [WIDTH-1:0] lo_q,
  input  logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output rd_state_t        state
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= RD_IDLE;
      bus_out <= '0;
      bus_oe  <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          bus_oe <= rd_lo | rd_hi;
          if (rd_lo) begin
            bus_out <= lo_q;
          end else if (rd_hi) begin
            bus_out <= hi_q;
          end
          if (rd_lo && rd_hi) begin
            state <= RD_HI_PEND;
          end
        end
        // Second word of a pair; any request seen now is dropped.
        RD_HI_PEND: begin
          bus_out <= hi_q;
          bus_oe  <= 1'b1;
          state   <= RD_IDLE;
        end
        default: begin
          bus_oe <= 1'b0;
          state  <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/hilo_capture_unit.sv
// Times the multiplier settle window after start, then latches the product into HI/LO.
// Optional zero/overflow status flags are built when HILO_STATUS_FLAGS_EN is defined.
module hilo_capture_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH         = DATA_W,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] mul_p,
  input  logic               rd_lo,
  input  logic               rd_hi,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi_q,
  output logic [WIDTH-1:0]   lo_q,
  output logic [WIDTH-1:0]   bus_out,
  output logic               bus_oe,
`ifdef HILO_STATUS_FLAGS_EN
  output logic               zero_f,
  output logic               ovf_f,
`endif
  output logic [2:0]         dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  cap_state_t       cap_state;
  rd_state_t        rd_state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cap_state <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef HILO_STATUS_FLAGS_EN
      zero_f    <= 1'b0;
      ovf_f     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (cap_state)
        IDLE: begin
          if (start) begin
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
            cap_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            done      <= 1'b1;
            cap_state <= CAPTURE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // done is high for this cycle; HI/LO take the product at its closing edge.
        CAPTURE: begin
          lo_q      <= mul_p[WIDTH-1:0];
          hi_q      <= mul_p[2*WIDTH-1:WIDTH];
`ifdef HILO_STATUS_FLAGS_EN
          zero_f    <= (mul_p == '0);
          ovf_f     <= (mul_p[2*WIDTH-1:WIDTH] != {WIDTH{mul_p[WIDTH-1]}});
`endif
          busy      <= 1'b0;
          cap_state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          cap_state <= IDLE;
        end
      endcase
    end
  end

  hilo_read_seq #(
    .WIDTH (WIDTH)
  ) u_read_seq (
    .clk     (clk),
    .clr_n   (clr_n),
    .rd_lo   (rd_lo),
    .rd_hi   (rd_hi),
    .lo_q    (lo_q),
    .hi_q    (hi_q),
    .bus_out (bus_out),
    .bus_oe  (bus_oe),
    .state   (rd_state)
  );

  assign dbg_state = {rd_state, cap_state};

endmodule

// File: tb/tb_hilo_capture_unit.sv
// Directed bench for hilo_capture_unit: capture timing, read sequencing, reset abort.
module tb_hilo_capture_unit;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [63:0] mul_p;
  logic        rd_lo;
  logic        rd_hi;
  logic        busy;
  logic        done;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] bus_out;
  logic        bus_oe;
  logic [2:0]  dbg_state;
`ifdef HILO_STATUS_FLAGS_EN
  logic        zero_f;
  logic        ovf_f;
`endif

  int total = 0;
  int bad   = 0;

  hilo_capture_unit #(
    .WIDTH         (32),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .mul_p     (mul_p),
    .rd_lo     (rd_lo),
    .rd_hi     (rd_hi),
    .busy      (busy),
    .done      (done),
    .hi_q      (hi_q),
    .lo_q      (lo_q),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
`ifdef HILO_STATUS_FLAGS_EN
    .zero_f    (zero_f),
    .ovf_f     (ovf_f),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [63:0] mul;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        o;
  } vec_t;

  vec_t vec[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a capture, wait (bounded) for done, return in the first cycle after CAPTURE.
  task automatic capture(input logic [63:0] v);
    int n;
    mul_p = v;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL capture_wait: done not seen within 40 cycles, got %b expected 1", done);
    end
    step();
  endtask

  initial begin
    vec[0] = '{64'h0000_0000_0000_002A, 32'h0000_002A, 32'h0000_0000, 1'b0, 1'b0};
    vec[1] = '{64'hFFFF_FFFF_FFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vec[2] = '{64'h0000_0001_0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1};
    vec[3] = '{64'h0000_0000_0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vec[4] = '{64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vec[5] = '{64'h0000_0000_8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1};

    clr_n = 1'b0;
    start = 1'b0;
    mul_p = '0;
    rd_lo = 1'b0;
    rd_hi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lo", lo_q, 0);
    check("rst_hi", hi_q, 0);
    check("rst_bus", bus_out, 0);
    check("rst_oe", bus_oe, 0);
    check("rst_state", dbg_state, 0);
    clr_n = 1'b1;
    step();

    // First capture: cycle-by-cycle timing, SETTLE_CYCLES=2
    mul_p = 64'h0000_0000_0000_002A;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_c1_busy", busy, 1);
    check("t1_c1_done", done, 0);
    check("t1_c1_state", dbg_state, 3'b001);
    step();
    check("t1_c2_busy", busy, 1);
    check("t1_c2_done", done, 0);
    step();
    check("t1_c3_busy", busy, 1);
    check("t1_c3_done", done, 1);
    check("t1_c3_state", dbg_state, 3'b010);
    check("t1_c3_lo_old", lo_q, 0);
    step();
    check("t1_c4_busy", busy, 0);
    check("t1_c4_done", done, 0);
    check("t1_c4_lo", lo_q, 32'h2A);
    check("t1_c4_hi", hi_q, 0);

    // Table of products: capture, then a LO/HI pair readback
    for (int i = 0; i < 6; i++) begin
      capture(vec[i].mul);
      check($sformatf("v%0d_lo", i), lo_q, vec[i].lo);
      check($sformatf("v%0d_hi", i), hi_q, vec[i].hi);
`ifdef HILO_STATUS_FLAGS_EN
      check($sformatf("v%0d_zero", i), zero_f, vec[i].z);
      check($sformatf("v%0d_ovf", i), ovf_f, vec[i].o);
`endif
      rd_lo = 1'b1;
      rd_hi = 1'b1;
      step();
      rd_lo = 1'b0;
      rd_hi = 1'b0;
      check($sformatf("v%0d_rd1_bus", i), bus_out, vec[i].lo);
      check($sformatf("v%0d_rd1_oe", i), bus_oe, 1);
      step();
      check($sformatf("v%0d_rd2_bus", i), bus_out, vec[i].hi);
      check($sformatf("v%0d_rd2_oe", i), bus_oe, 1);
      step();
      check($sformatf("v%0d_rd3_oe", i), bus_oe, 0);
    end

    // Pair read of -7 with a rd_lo dropped during the LO cycle
    capture(64'hFFFF_FFFF_FFFF_FFF9);
    rd_lo = 1'b1;
    rd_hi = 1'b1;
    step();
    rd_hi = 1'b0;
    check("t2_lo_bus", bus_out, 32'hFFFF_FFF9);
    check("t2_lo_oe", bus_oe, 1);
    step();
    rd_lo = 1'b0;
    check("t2_hi_bus", bus_out, 32'hFFFF_FFFF);
    check("t2_hi_oe", bus_oe, 1);
    step();
    check("t2_drop_oe", bus_oe, 0);
    check("t2_hold_bus", bus_out, 32'hFFFF_FFFF);

    // start held while busy and in the done cycle is ignored; rd_hi during SETTLE sees old HI
    mul_p = 64'h0000_0011_0000_0022;
    start = 1'b1;
    step();
    rd_hi = 1'b1;
    step();
    rd_hi = 1'b0;
    check("t3_rdhi_bus", bus_out, 32'hFFFF_FFFF);
    check("t3_rdhi_oe", bus_oe, 1);
    step();
    check("t3_done", done, 1);
    step();
    start = 1'b0;
    check("t3_busy_after", busy, 0);
    check("t3_lo", lo_q, 32'h22);
    check("t3_hi", hi_q, 32'h11);
    mul_p = 64'h1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t3_idle%0d_done", k), done, 0);
      check($sformatf("t3_idle%0d_busy", k), busy, 0);
    end
    check("t3_lo_kept", lo_q, 32'h22);
    check("t3_hi_kept", hi_q, 32'h11);

    // Read in the CAPTURE cycle returns old LO; one cycle later the new LO
    capture(64'h5);
    mul_p = 64'h9;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("t6_done", done, 1);
    rd_lo = 1'b1;
    step();
    check("t6_old_bus", bus_out, 32'h5);
    check("t6_old_oe", bus_oe, 1);
    check("t6_new_lo", lo_q, 32'h9);
    step();
    rd_lo = 1'b0;
    check("t6_new_bus", bus_out, 32'h9);
    check("t6_new_oe", bus_oe, 1);
    step();

    // Asynchronous reset during SETTLE aborts the capture
    mul_p = 64'h1234;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_settle_busy", busy, 1);
    #2;
    clr_n = 1'b0;
    #1;
    check("t4_async_busy", busy, 0);
    check("t4_async_lo", lo_q, 0);
    check("t4_async_hi", hi_q, 0);
    check("t4_async_bus", bus_out, 0);
    check("t4_async_oe", bus_oe, 0);
    check("t4_async_state", dbg_state, 0);
    step();
    clr_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t4_post%0d_done", k), done, 0);
      check($sformatf("t4_post%0d_lo", k), lo_q, 0);
    end
    check("t4_post_hi", hi_q, 0);
    check("t4_post_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_capture_unit.md
Name: hilo_capture_unit

Overview:
- Sequential stage directly downstream of the 32x32 combinational multiplier.
- Times the multiplier's settle window after a launch, then captures the 64-bit product into the HI and LO registers.
- Serves reads of HI and LO onto the 32-bit datapath bus, either as single-word or back-to-back two-word transfers.
- Keeps capture and readout cycle-deterministic for the control unit.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- SETTLE_CYCLES, 2, cycles between start and product sample (combinational multiply path budget); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  launch pulse; multiplier operands are stable from this cycle until done.
- mul_p  in  2*WIDTH  product from multiplier.
- rd_lo  in  1  request LO onto bus.
- rd_hi  in  1  request HI onto bus.
- busy  out  1  capture in progress.
- done  out  1  one-cycle pulse when HI/LO are updated.
- hi_q  out  WIDTH  HI register.
- lo_q  out  WIDTH  LO register.
- bus_out  out  WIDTH  registered bus data.
- bus_oe  out  1  bus_out valid this cycle.

Behaviour:
- Reset (clr_n=0, async): state=IDLE, counter=0, hi_q=0, lo_q=0, bus_out=0, bus_oe=0, busy=0, done=0. Reset mid-capture or mid-read aborts with no partial update.
- Capture FSM:
  - IDLE: start=1 loads counter with SETTLE_CYCLES-1, goes to SETTLE, busy=1 next cycle.
  - SETTLE: decrement each cycle; when counter==0, go to CAPTURE.
  - CAPTURE: lo_q<=mul_p[WIDTH-1:0], hi_q<=mul_p[2*WIDTH-1:WIDTH], done=1 for this one cycle, busy stays 1, return to IDLE. busy=0 in the following cycle.
- Capture timing: start at edge N gives HI/LO updated at edge N+SETTLE_CYCLES+1.
- start while busy=1: ignored, no queueing.
- start in the same cycle done=1: ignored. A new start is accepted only when busy=0.
- Read path (independent of capture FSM): requests are sampled each cycle only when the read sequencer is idle.
  - rd_lo alone: next cycle bus_out=lo_q, bus_oe=1.
  - rd_hi alone: next cycle bus_out=hi_q, bus_oe=1.
  - rd_lo and rd_hi together: cycle+1 drives LO, cycle+2 drives HI, bus_oe=1 both cycles. Requests arriving during cycle+1 are dropped.
  - A read accepted while busy=1 returns the pre-capture register values. Reads never stall.
  - A read sampled in the CAPTURE cycle returns the old value. A read sampled one cycle later returns the new value.
  - bus_oe=0 otherwise; bus_out holds its last value when bus_oe=0.
- Arithmetic: no arithmetic on the product; raw 2*WIDTH bits are split HI/LO. Sign interpretation belongs to the multiplier.

Optional Feature:
- Macro HILO_STATUS_FLAGS_EN.
- When defined:
  - Adds outputs zero_f (1) and ovf_f (1), registered in CAPTURE alongside HI/LO.
  - zero_f = (mul_p==0).
  - ovf_f = 1 when mul_p[2*WIDTH-1:WIDTH] is not all copies of mul_p[WIDTH-1] (product does not fit in WIDTH signed bits).
  - Both flags reset to 0.
- When undefined: the ports do not exist and there is no flag logic.

Decomposition:
- Shared package cpu_pkg holds:
  - Capture state enum: IDLE, SETTLE, CAPTURE.
  - Read-sequencer enum: RD_IDLE, RD_HI_PEND.
  - DATA_W=32 constant.
- One natural sub-module: hilo_read_seq (read request sampling and the two-word LO/HI sequencer), instantiated once.

Test Plan:
- Reset, then mul_p=64'h0000_0000_0000_002A, start pulse, SETTLE_CYCLES=2 -> done at cycle 3 after start, lo_q=32'h2A, hi_q=0, busy high for exactly 3 cycles.
- mul_p=64'hFFFF_FFFF_FFFF_FFF9 (-7) captured, then rd_lo&rd_hi in one cycle -> bus_out=FFFF_FFF9 then FFFF_FFFF on consecutive cycles with bus_oe=1 both cycles; a rd_lo during the first of those cycles is dropped.
- Second start asserted while busy with mul_p changed to 64'h1 -> ignored; HI/LO keep the first capture; a rd_hi during SETTLE returns the old hi_q.
- clr_n pulled low during SETTLE with mul_p=64'h1234 -> all outputs 0 asynchronously, no done, hi_q/lo_q remain 0 after release.
- HILO_STATUS_FLAGS_EN defined:
  - mul_p=64'h0000_0001_0000_0000 -> ovf_f=1, zero_f=0.
  - mul_p=0 -> zero_f=1, ovf_f=0.
  - mul_p=64'hFFFF_FFFF_8000_0000 -> ovf_f=0.
- Read in the CAPTURE cycle returns the old LO; read one cycle later returns the new LO (old 5, new 9 -> bus_out 5 then 9).
